mram_burst_sequencer: RTL and testbench

- Executes read and write bus cycles on the external parallel MRAM, with burst and auto-increment support.
- Sits downstream of the serial-to-parallel data and address deserializers. Read words go back to the parallel-to-serial return path.
- Takes one command per burst on a valid/ready handshake, streams write words in and read words out, and generates MRAM strobes with parameterised wait states.

---
 rtl/mram_burst_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mram_burst_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mram_burst_sequencer.sv
// Bus-cycle sequencer for an external parallel MRAM: one command per burst,
// auto-incrementing word address, registered strobes with parameterised wait states.
module mram_burst_sequencer #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int LEN_WIDTH   = 8,
    parameter int WR_CYCLES   = 4,
    parameter int RD_CYCLES   = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_byte_sel,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mram_addr,
    output logic [DATA_WIDTH-1:0] mram_dq_out,
    output logic                  mram_dq_oe,
    input  logic [DATA_WIDTH-1:0] mram_dq_in,
    output logic                  chip_en_n,
    output logic                  write_en_n,
    output logic                  out_en_n,
    output logic                  lower_byte_en_n,
    output logic                  upper_byte_en_n
);

    localparam int CNT_W = 16;
    localparam int HALF  = DATA_WIDTH / 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_PULSE,
        RD_WAIT,
        RD_PRESENT,
        RECOVER
    } state_t;

    state_t               state;
    logic                 is_write;
    logic [1:0]           byte_sel;
    logic [LEN_WIDTH-1:0] remaining;
    logic [CNT_W-1:0]     cnt;

    // Returns {upper_byte_en_n, lower_byte_en_n} for a byte-select code.
    function automatic logic [1:0] lanes(input logic [1:0] sel);
        case (sel)
            2'b01:   lanes = 2'b10;
            2'b10:   lanes = 2'b01;
            default: lanes = 2'b00;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] capture(input logic [1:0] sel,
                                                      input logic [DATA_WIDTH-1:0] dq);
        case (sel)
            2'b01:   capture = {{(DATA_WIDTH-HALF){1'b0}}, dq[HALF-1:0]};
            2'b10:   capture = {{(DATA_WIDTH-HALF){1'b0}}, dq[DATA_WIDTH-1:HALF]};
            default: capture = dq;
        endcase
    endfunction

    // All outputs are registered; each transition sets the strobes for the state it enters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            is_write        <= 1'b0;
            byte_sel        <= 2'b00;
            remaining       <= '0;
            cnt             <= '0;
            cmd_ready       <= 1'b0;
            wdata_ready     <= 1'b0;
            rdata           <= '0;
            rdata_valid     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mram_addr       <= '0;
            mram_dq_out     <= '0;
            mram_dq_oe      <= 1'b0;
            chip_en_n       <= 1'b1;
            write_en_n      <= 1'b1;
            out_en_n        <= 1'b1;
            lower_byte_en_n <= 1'b1;
            upper_byte_en_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        is_write    <= cmd_write;
                        byte_sel    <= cmd_byte_sel;
                        remaining   <= cmd_len;
                        mram_addr   <= cmd_addr;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        chip_en_n   <= 1'b0;
                        {upper_byte_en_n, lower_byte_en_n} <= lanes(cmd_byte_sel);
                        wdata_ready <= cmd_write;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (is_write) begin
                        if (wdata_valid && wdata_ready) begin
                            wdata_ready <= 1'b0;
                            mram_dq_out <= wdata;
                            mram_dq_oe  <= 1'b1;
                            write_en_n  <= 1'b0;
                            cnt         <= CNT_W'(WR_CYCLES - 1);
                            state       <= WR_PULSE;
                        end
                    end else begin
                        out_en_n <= 1'b0;
                        cnt      <= CNT_W'(RD_CYCLES - 1);
                        state    <= RD_WAIT;
                    end
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        write_en_n      <= 1'b1;
                        chip_en_n       <= 1'b1;
                        lower_byte_en_n <= 1'b1;
                        upper_byte_en_n <= 1'b1;
                        cnt             <= CNT_W'(TURN_CYCLES - 1);
                        done            <= (remaining == '0) && (TURN_CYCLES == 1);
                        state           <= RECOVER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        out_en_n        <= 1'b1;
                        chip_en_n       <= 1'b1;
                        lower_byte_en_n <= 1'b1;
                        upper_byte_en_n <= 1'b1;
                        rdata           <= capture(byte_sel, mram_dq_in);
                        rdata_valid     <= 1'b1;
                        state           <= RD_PRESENT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RD_PRESENT: begin
                    if (rdata_ready) begin
                        rdata_valid <= 1'b0;
                        cnt         <= CNT_W'(TURN_CYCLES - 1);
                        done        <= (remaining == '0) && (TURN_CYCLES == 1);
                        state       <= RECOVER;
                    end
                end
                RECOVER: begin
                    // Write data stays driven through recovery as hold time, released on exit.
                    if (cnt == '0) begin
                        mram_dq_oe <= 1'b0;
                        if (remaining != '0) begin
                            remaining   <= remaining - LEN_WIDTH'(1);
                            mram_addr   <= mram_addr + ADDR_WIDTH'(1);
                            chip_en_n   <= 1'b0;
                            {upper_byte_en_n, lower_byte_en_n} <= lanes(byte_sel);
                            wdata_ready <= is_write;
                            state       <= SETUP;
                        end else begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt  <= cnt - CNT_W'(1);
                        done <= (cnt == CNT_W'(1)) && (remaining == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mram_burst_sequencer.sv
// Directed bench for mram_burst_sequencer: hand-computed expectations checked
// with immediate assertions, using a simple address-derived MRAM read model.
module tb_mram_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_byte_sel = 2'b00;
    logic [19:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [15:0] wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        rdata_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [19:0] mram_addr;
    logic [15:0] mram_dq_out;
    logic        mram_dq_oe;
    logic [15:0] mram_dq_in;
    logic        chip_en_n;
    logic        write_en_n;
    logic        out_en_n;
    logic        lower_byte_en_n;
    logic        upper_byte_en_n;

    logic        force_dq = 1'b0;
    logic [15:0] dq_fixed = '0;
    int          errors = 0;
    int          checks = 0;
    int          done_count = 0;

    assign mram_dq_in = force_dq ? dq_fixed : (mram_addr[15:0] ^ 16'h5A5A);

    always #5 clk = ~clk;

    mram_burst_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_byte_sel(cmd_byte_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .busy(busy), .done(done),
        .mram_addr(mram_addr), .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe),
        .mram_dq_in(mram_dq_in),
        .chip_en_n(chip_en_n), .write_en_n(write_en_n), .out_en_n(out_en_n),
        .lower_byte_en_n(lower_byte_en_n), .upper_byte_en_n(upper_byte_en_n)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [1:0] bs,
                                  input logic [19:0] a, input logic [7:0] len);
        cmd_valid    = 1'b1;
        cmd_write    = wr;
        cmd_byte_sel = bs;
        cmd_addr     = a;
        cmd_len      = len;
    endtask

    // Counts from the current cycle (1) until rdata_valid, tallying out_en_n low cycles.
    task automatic wait_valid(output int n, output int oen);
        n   = 1;
        oen = 0;
        while (!rdata_valid && n < 50) begin
            if (!out_en_n) oen++;
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready) break;
            tick();
        end
        check_output("idle_timeout", {31'b0, cmd_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst && done) done_count++;
        if (rst && !out_en_n) check_output("oe_during_read", {31'b0, mram_dq_oe}, 32'd0);
    end

    initial begin
        int n, oen, base_done, done_c, acc;
        logic [19:0] rd_addr [4];
        logic [15:0] rd_data [4];
        rd_addr = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        rd_data = '{16'hA5A4, 16'hA5A5, 16'h5A5A, 16'h5A5B};

        $display("[TB] reset state");
        tick();
        tick();
        check_output("rst_strobes", {27'b0, chip_en_n, write_en_n, out_en_n,
                     lower_byte_en_n, upper_byte_en_n}, 32'h1F);
        check_output("rst_ctrl", {26'b0, mram_dq_oe, cmd_ready, wdata_ready,
                     rdata_valid, busy, done}, 32'h0);
        check_output("rst_addr", {12'b0, mram_addr}, 32'h0);
        check_output("rst_dq_out", {16'b0, mram_dq_out}, 32'h0);
        check_output("rst_rdata", {16'b0, rdata}, 32'h0);
        rst = 1'b1;
        tick();
        check_output("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

        $display("[TB] single full-word write");
        apply_stimulus(1'b1, 2'b00, 20'h00010, 8'd0);
        wdata       = 16'hBEEF;
        wdata_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_output("wr_c1_ce", {31'b0, chip_en_n}, 32'd0);
        check_output("wr_c1_we", {31'b0, write_en_n}, 32'd1);
        check_output("wr_c1_wready", {31'b0, wdata_ready}, 32'd1);
        check_output("wr_c1_addr", {12'b0, mram_addr}, 32'h00010);
        check_output("wr_c1_be", {30'b0, upper_byte_en_n, lower_byte_en_n}, 32'd0);
        check_output("wr_c1_busy_rdy", {30'b0, busy, cmd_ready}, 32'b10);
        tick();
        wdata_valid = 1'b0;
        check_output("wr_c2_we", {31'b0, write_en_n}, 32'd0);
        check_output("wr_c2_dq", {16'b0, mram_dq_out}, 32'hBEEF);
        check_output("wr_c2_oe", {31'b0, mram_dq_oe}, 32'd1);
        check_output("wr_c2_wready", {31'b0, wdata_ready}, 32'd0);
        for (int c = 3; c <= 7; c++) begin
            tick();
            check_output($sformatf("wr_c%0d_we", c), {31'b0, write_en_n}, (c <= 5) ? 32'd0 : 32'd1);
            check_output($sformatf("wr_c%0d_done", c), {31'b0, done}, (c == 6) ? 32'd1 : 32'd0);
            check_output($sformatf("wr_c%0d_oe", c), {31'b0, mram_dq_oe}, (c <= 6) ? 32'd1 : 32'd0);
            check_output($sformatf("wr_c%0d_ready", c), {31'b0, cmd_ready}, (c == 7) ? 32'd1 : 32'd0);
        end

        $display("[TB] read burst across address wrap");
        base_done = done_count;
        rdata_ready = 1'b1;
        apply_stimulus(1'b0, 2'b00, 20'hFFFFE, 8'd3);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(n, oen);
            check_output($sformatf("rd%0d_latency", k), n, (k == 0) ? 32'd6 : 32'd7);
            check_output($sformatf("rd%0d_oen_len", k), oen, 32'd4);
            check_output($sformatf("rd%0d_addr", k), {12'b0, mram_addr}, {12'b0, rd_addr[k]});
            check_output($sformatf("rd%0d_data", k), {16'b0, rdata}, {16'b0, rd_data[k]});
            check_output($sformatf("rd%0d_strobes", k), {29'b0, chip_en_n, out_en_n, write_en_n}, 32'h7);
            tick();
        end
        check_output("rd_burst_done", {31'b0, done}, 32'd1);
        tick();
        check_output("rd_burst_idle", {30'b0, busy, cmd_ready}, 32'b01);
        check_output("rd_burst_done_cnt", done_count - base_done, 32'd1);

        $display("[TB] byte-lane reads");
        force_dq = 1'b1;
        dq_fixed = 16'h12AB;
        apply_stimulus(1'b0, 2'b10, 20'h00123, 8'd0);
        tick();
        cmd_valid = 1'b0;
        check_output("up_be", {30'b0, upper_byte_en_n, lower_byte_en_n}, 32'b01);
        wait_valid(n, oen);
        check_output("up_rdata", {16'b0, rdata}, 32'h0012);
        tick();
        wait_idle();
        apply_stimulus(1'b0, 2'b01, 20'h00124, 8'd0);
        tick();
        cmd_valid = 1'b0;
        check_output("lo_be", {30'b0, upper_byte_en_n, lower_byte_en_n}, 32'b10);
        wait_valid(n, oen);
        check_output("lo_rdata", {16'b0, rdata}, 32'h00AB);
        tick();
        wait_idle();
        force_dq = 1'b0;

        $display("[TB] read with consumer stall");
        rdata_ready = 1'b0;
        apply_stimulus(1'b0, 2'b00, 20'h00040, 8'd0);
        tick();
        cmd_valid = 1'b0;
        wait_valid(n, oen);
        check_output("stall_latency", n, 32'd6);
        for (int s = 0; s < 3; s++) begin
            tick();
            check_output("stall_valid", {31'b0, rdata_valid}, 32'd1);
            check_output("stall_rdata", {16'b0, rdata}, 32'h5A1A);
            check_output("stall_oen", {31'b0, out_en_n}, 32'd1);
        end
        rdata_ready = 1'b1;
        tick();
        check_output("stall_release", {30'b0, rdata_valid, done}, 32'b01);
        tick();
        check_output("stall_idle", {31'b0, busy}, 32'd0);

        $display("[TB] gapped write burst");
        base_done = done_count;
        apply_stimulus(1'b1, 2'b00, 20'h00200, 8'd2);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < 5; g++) begin
                check_output("gap_wready", {31'b0, wdata_ready}, 32'd1);
                check_output("gap_strobes", {30'b0, chip_en_n, write_en_n}, 32'b01);
                tick();
            end
            check_output($sformatf("gap%0d_addr", k), {12'b0, mram_addr}, 32'h00200 + k);
            wdata       = 16'h1111 * (k + 1);
            wdata_valid = 1'b1;
            tick();
            wdata_valid = 1'b0;
            check_output($sformatf("gap%0d_dq", k), {16'b0, mram_dq_out}, 32'h1111 * (k + 1));
            n = 0;
            while (!write_en_n && n < 20) begin
                n++;
                tick();
            end
            check_output($sformatf("gap%0d_we_len", k), n, 32'd4);
            check_output($sformatf("gap%0d_hold_oe", k), {31'b0, mram_dq_oe}, 32'd1);
            check_output($sformatf("gap%0d_ce", k), {31'b0, chip_en_n}, 32'd1);
            check_output($sformatf("gap%0d_done", k), {31'b0, done}, (k == 2) ? 32'd1 : 32'd0);
            tick();
            check_output($sformatf("gap%0d_oe_off", k), {31'b0, mram_dq_oe}, 32'd0);
        end
        check_output("gap_idle", {30'b0, busy, cmd_ready}, 32'b01);
        check_output("gap_done_cnt", done_count - base_done, 32'd1);

        $display("[TB] reset during write pulse");
        base_done = done_count;
        apply_stimulus(1'b1, 2'b00, 20'h00500, 8'd0);
        wdata       = 16'hCAFE;
        wdata_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        wdata = 16'h7777;
        check_output("mid_c2_we", {31'b0, write_en_n}, 32'd0);
        tick();
        check_output("mid_c3_we", {31'b0, write_en_n}, 32'd0);
        rst = 1'b0;
        tick();
        check_output("mid_rst_strobes", {29'b0, write_en_n, chip_en_n, mram_dq_oe}, 32'b110);
        check_output("mid_rst_ctrl", {28'b0, done, busy, wdata_ready, cmd_ready}, 32'd0);
        check_output("mid_rst_dq", {16'b0, mram_dq_out}, 32'h0);
        rst = 1'b1;
        tick();
        check_output("mid_release_ready", {31'b0, cmd_ready}, 32'd1);
        check_output("mid_release_wready", {31'b0, wdata_ready}, 32'd0);
        check_output("mid_release_dq", {16'b0, mram_dq_out}, 32'h0);
        wdata_valid = 1'b0;
        check_output("mid_no_done", done_count - base_done, 32'd0);

        $display("[TB] command held valid across a busy burst");
        done_c = -1;
        acc    = -1;
        apply_stimulus(1'b0, 2'b00, 20'h00300, 8'd0);
        tick();
        for (int c = 1; c < 40; c++) begin
            if (done) done_c = c;
            if (cmd_ready) begin
                acc = c;
                break;
            end
            tick();
        end
        check_output("hold_done_cycle", done_c, 32'd7);
        check_output("hold_accept_cycle", acc, 32'd8);
        tick();
        cmd_valid = 1'b0;
        check_output("hold_second_busy", {30'b0, busy, cmd_ready}, 32'b10);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
